// File: rtl/gate_response_misr_if.sv
// rtl/gate_response_misr_if.sv - response vector valid/ready handshake bundle
//
// Purpose: carries one gate-model response vector per transfer.
// Signals:
//   resp_valid  producer -> block  resp holds a valid vector
//   resp        producer -> block  response vector (RESP_W bits)
//   resp_ready  block -> producer  block accepts resp this cycle
// Modports: master (producer side), slave (compactor side).
interface gate_response_misr_if #(
  parameter int RESP_W = 10
);
  logic              resp_valid;
  logic [RESP_W-1:0] resp;
  logic              resp_ready;

  modport master (output resp_valid, output resp, input resp_ready);
  modport slave  (input resp_valid, input resp, output resp_ready);
endinterface

// File: rtl/gate_response_misr.sv
// rtl/gate_response_misr.sv - MISR response compactor with pass/fail check
//
// Purpose: folds accepted response vectors into a multiple-input signature
// register, counts them, and compares the final signature to a golden value.
// Ports:
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         begin a run (honoured in IDLE or DONE only)
//   i_num_vec       vectors to compact, latched on an accepted start
//   i_expected_sig  golden signature, sampled at the completion edge
//   bus             response handshake (slave side)
//   o_busy          high while a run is in progress
//   o_done          high once the run has finished
//   o_pass          signature matched expected; valid while o_done=1
//   o_signature     current MISR contents
//   o_vec_count     vectors accepted in the current run
module gate_response_misr #(
  parameter int               RESP_W = 10,
  parameter int               SIG_W  = 16,
  parameter int               CNT_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_num_vec,
  input  logic [SIG_W-1:0]     i_expected_sig,
  gate_response_misr_if.slave  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [SIG_W-1:0]     o_signature,
  output logic [CNT_W-1:0]     o_vec_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_num;
  logic             r_pass;

  state_t           w_state_d;
  logic [SIG_W-1:0] w_sig_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_num_d;
  logic             w_pass_d;

  logic [SIG_W-1:0] w_resp_ext;
  logic [SIG_W-1:0] w_sig_next;
  logic [CNT_W-1:0] w_cnt_inc;

  // Response is zero-extended into the low bits of the signature.
  always_comb begin
    w_resp_ext               = '0;
    w_resp_ext[RESP_W-1:0]   = bus.resp;
  end

  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY : '0)
                    ^ w_resp_ext;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_num   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sig   <= w_sig_d;
      r_cnt   <= w_cnt_d;
      r_num   <= w_num_d;
      r_pass  <= w_pass_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sig_d   = r_sig;
    w_cnt_d   = r_cnt;
    w_num_d   = r_num;
    w_pass_d  = r_pass;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_sig_d  = SEED;
          w_cnt_d  = '0;
          w_num_d  = i_num_vec;
          if (i_num_vec == '0) begin
            // Empty run: the seed itself is the final signature.
            w_state_d = S_DONE;
            w_pass_d  = (SEED == i_expected_sig);
          end else begin
            w_state_d = S_RUN;
            w_pass_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        // resp_ready is high for the whole of RUN, so valid alone is an accept.
        if (bus.resp_valid) begin
          w_sig_d = w_sig_next;
          w_cnt_d = w_cnt_inc;
          if (w_cnt_inc == r_num) begin
            w_state_d = S_DONE;
            w_pass_d  = (w_sig_next == i_expected_sig);
          end
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  assign bus.resp_ready = (r_state == S_RUN);
  assign o_busy         = (r_state == S_RUN);
  assign o_done         = (r_state == S_DONE);
  assign o_pass         = r_pass;
  assign o_signature    = r_sig;
  assign o_vec_count    = r_cnt;

endmodule

// File: tb/tb_gate_response_misr.sv
// tb/tb_gate_response_misr.sv - self-checking bench for gate_response_misr
module tb_gate_response_misr;

  localparam logic [15:0] M_SEED = 16'h0000;
  localparam logic [15:0] M_POLY = 16'h1021;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic [15:0] expected_sig = '0;
  logic        busy, done, pass;
  logic [15:0] signature, vec_count;

  logic        b_start = 1'b0;
  logic [15:0] b_num = '0;
  logic [15:0] b_exp = '0;
  logic        b_busy, b_done, b_pass;
  logic [15:0] b_sig, b_cnt;

  int n_err    = 0;
  int n_checks = 0;

  gate_response_misr_if #(.RESP_W(10)) bus ();
  gate_response_misr_if #(.RESP_W(10)) bus2 ();

  gate_response_misr dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_vec(num_vec),
    .i_expected_sig(expected_sig), .bus(bus.slave),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_signature(signature), .o_vec_count(vec_count)
  );

  gate_response_misr #(.SEED(16'h8000)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_num_vec(b_num),
    .i_expected_sig(b_exp), .bus(bus2.slave),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_signature(b_sig), .o_vec_count(b_cnt)
  );

  always #5 clk = ~clk;

  // Multiply signature by x modulo the feedback polynomial, then add the vector.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] r);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ {1'b1, M_POLY};
    return t[15:0] ^ {6'b0, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: phase 0 idle, 1 collecting, 2 finished.
  int         m_phase  = 0;
  int         m_target = 0;
  bit         m_pass   = 1'b0;
  logic [9:0] m_acc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_pass  = 1'b0;
      m_acc.delete();
    end else if (m_phase == 1) begin
      if (bus.resp_valid) begin
        logic [15:0] s;
        m_acc.push_back(bus.resp);
        if (m_acc.size() == m_target) begin
          s = M_SEED;
          foreach (m_acc[i]) s = misr_step(s, m_acc[i]);
          m_phase = 2;
          m_pass  = (s == expected_sig);
        end
      end
    end else if (start) begin
      m_acc.delete();
      m_target = int'(num_vec);
      if (num_vec == 16'd0) begin
        m_phase = 2;
        m_pass  = (M_SEED == expected_sig);
      end else begin
        m_phase = 1;
        m_pass  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] es;
    es = M_SEED;
    foreach (m_acc[i]) es = misr_step(es, m_acc[i]);
    chk("cmp_signature", signature, es);
    chk("cmp_vec_count", vec_count, m_acc.size());
    chk("cmp_resp_ready", bus.resp_ready, m_phase == 1);
    chk("cmp_busy", busy, m_phase == 1);
    chk("cmp_done", done, m_phase == 2);
    if (m_phase == 2) chk("cmp_pass", pass, m_pass);
  end

  logic [9:0] plan[8];
  int         gap[8];

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [15:0] plan_fold(input int n);
    logic [15:0] s;
    s = M_SEED;
    for (int k = 0; k < n; k++) s = misr_step(s, plan[k]);
    return s;
  endfunction

  task automatic do_run(input int n, input logic [15:0] exp, input bit noise);
    logic [15:0] g;
    g = plan_fold(n);
    start = 1'b1; num_vec = 16'(n); expected_sig = exp;
    cyc();
    start = 1'b0;
    chk("start_reload_sig", signature, M_SEED);
    chk("start_clear_cnt", vec_count, 0);
    for (int k = 0; k < n; k++) begin
      bus.resp_valid = 1'b0;
      for (int q = 0; q < gap[k]; q++) begin
        bus.resp = 10'($urandom);
        start    = noise && ($urandom_range(0, 3) == 0);
        num_vec  = 16'($urandom);
        cyc();
      end
      start = noise && ($urandom_range(0, 3) == 0);
      bus.resp_valid = 1'b1; bus.resp = plan[k];
      cyc();
    end
    bus.resp_valid = 1'b0; start = 1'b0;
    chk("run_done", done, 1);
    chk("run_signature", signature, g);
    chk("run_pass", pass, g == exp);
    cyc();
  endtask

  initial begin
    bus.resp_valid = 1'b0; bus.resp = '0;
    bus2.resp_valid = 1'b0; bus2.resp = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    chk("reset_sig", signature, 16'h0000);
    chk("reset_cnt", vec_count, 0);
    chk("reset_ready", bus.resp_ready, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    rst_n = 1'b1;
    cyc();

    chk("pin_step_3ff", misr_step(16'h0000, 10'h3FF), 16'h03FF);
    chk("pin_step_001", misr_step(16'h03FF, 10'h001), 16'h07FF);
    chk("pin_step_tap", misr_step(16'h8000, 10'h000), 16'h1021);

    // Basic compaction.
    start = 1'b1; num_vec = 16'd2; expected_sig = 16'h07FF;
    cyc();
    start = 1'b0;
    bus.resp_valid = 1'b1; bus.resp = 10'h3FF;
    cyc();
    chk("basic_sig1", signature, 16'h03FF);
    chk("basic_done1", done, 0);
    bus.resp = 10'h001;
    cyc();
    bus.resp_valid = 1'b0;
    chk("basic_sig2", signature, 16'h07FF);
    chk("basic_done2", done, 1);
    chk("basic_pass2", pass, 1);
    cyc();

    // Feedback tap on the 0x8000-seeded instance.
    b_start = 1'b1; b_num = 16'd1; b_exp = 16'h1020;
    cyc();
    b_start = 1'b0;
    chk("tap_seed", b_sig, 16'h8000);
    bus2.resp_valid = 1'b1; bus2.resp = 10'h000;
    cyc();
    bus2.resp_valid = 1'b0;
    chk("tap_sig", b_sig, 16'h1021);
    chk("tap_done", b_done, 1);
    chk("tap_pass", b_pass, 0);

    // Stalls of 0, 2 and 5 cycles.
    plan[0] = 10'h155; plan[1] = 10'h2AA; plan[2] = 10'h0F0;
    gap[0] = 0; gap[1] = 2; gap[2] = 5;
    do_run(3, plan_fold(3), 1'b0);

    // Zero-length run.
    do_run(0, M_SEED, 1'b0);

    // Start pulses during RUN are ignored.
    for (int k = 0; k < 4; k++) begin plan[k] = 10'($urandom); gap[k] = 1; end
    do_run(4, 16'h1234, 1'b1);

    // Reset mid-run after 3 of 5 accepts.
    for (int k = 0; k < 5; k++) plan[k] = 10'($urandom);
    start = 1'b1; num_vec = 16'd5; expected_sig = 16'h0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.resp_valid = 1'b1; bus.resp = plan[k];
      cyc();
    end
    chk("midrst_cnt_before", vec_count, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_sig", signature, 16'h0000);
    chk("midrst_cnt", vec_count, 0);
    chk("midrst_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    bus.resp = 10'h3FF;
    for (int k = 0; k < 3; k++) cyc();
    bus.resp_valid = 1'b0;
    chk("postrst_sig", signature, 16'h0000);
    chk("postrst_cnt", vec_count, 0);
    chk("postrst_ready", bus.resp_ready, 0);

    // Randomised runs.
    for (int r = 0; r < 40; r++) begin
      int          n;
      logic [15:0] g, e;
      n = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++) begin
        plan[k] = 10'($urandom);
        gap[k]  = $urandom_range(0, 3);
      end
      g = plan_fold(n);
      e = ($urandom_range(0, 1) == 1) ? g : (g ^ (16'($urandom) | 16'h0001));
      if ($urandom_range(0, 2) == 0) begin
        bus.resp_valid = 1'b1; bus.resp = 10'($urandom);
        cyc();
        bus.resp_valid = 1'b0;
      end
      do_run(n, e, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_response_misr.md
Name: gate_response_misr

Overview:
- Downstream response compactor for the 15-input/10-output combinational gate-model netlists in the simulator gate library.
- Accepts one 10-bit output vector per applied test pattern over a valid/ready handshake.
- Folds each accepted vector into a multiple-input signature register (MISR), counts vectors, and compares the final signature against an expected value.
- Produces a single pass/fail result per test run.

Parameters:
- RESP_W, 10, width of the response vector (gate-model outputs, packed in a fixed order).
- SIG_W, 16, signature register width; must be >= RESP_W.
- CNT_W, 16, width of the vector counter and num_vec.
- POLY, 16'h1021, MISR feedback polynomial; bit i set means a tap into bit i.
- SEED, 16'h0000, signature value loaded at start.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- num_vec  in  CNT_W  number of vectors to compact; sampled on the accepted start.
- expected_sig  in  SIG_W  golden signature; compared when the run finishes.
- resp_valid  in  1  resp holds a valid vector.
- resp  in  RESP_W  gate-model response vector.
- resp_ready  out  1  block accepts resp this cycle.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  signature == expected_sig; meaningful only while done=1.
- signature  out  SIG_W  current MISR contents.
- vec_count  out  CNT_W  vectors accepted in the current run.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - signature=SEED, vec_count=0.
  - resp_ready=0, busy=0, done=0, pass=0.
  - A reset mid-run aborts the run; no partial result is kept.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- IDLE or DONE with start=1:
  - Load signature=SEED, clear vec_count, latch num_vec, clear pass.
  - If num_vec != 0, go to RUN.
  - If num_vec == 0, go to DONE with pass = (SEED == expected_sig) on the next cycle.
- RUN:
  - resp_ready=1.
  - An accept occurs on a cycle with resp_valid && resp_ready.
  - Stall cycles (resp_valid=0) hold all state.
- MISR update on each accept, in the same clock edge:
  - sig_next = {signature[SIG_W-2:0],1'b0} XOR (signature[SIG_W-1] ? POLY : 0) XOR zero_extend(resp).
  - vec_count increments by 1.
- Run completion:
  - On the accept where vec_count+1 == latched num_vec, go to DONE.
  - pass is registered from the comparison of sig_next against expected_sig.
  - done rises the cycle after the last accept (1-cycle latency); resp_ready drops the same cycle.
- DONE:
  - done, pass and signature hold until a new start or reset.
  - resp_valid is ignored.
- start while in RUN is ignored.
- resp_valid outside RUN is ignored (resp_ready=0); no signature change.
- Width rules:
  - vec_count saturates never; a run ends exactly at num_vec.
  - Maximum run length is 2^CNT_W-1 vectors.
- expected_sig is sampled only at the completion edge; changes at any other time have no effect.

Test Plan:
- Reset mid-run: after 3 accepts of num_vec=5, pulse rst_n low -> signature=0x0000, vec_count=0, IDLE; any resp_valid ignored until a new start.
- Basic compaction: SEED=0, num_vec=2, resp 0x3FF then 0x001, expected_sig=0x07FF -> signature 0x03FF, then 0x07FF; done=1 and pass=1 one cycle after the second accept.
- Feedback tap: SEED=0x8000, num_vec=1, resp 0x000 -> signature=0x1021; expected_sig=0x1020 gives pass=0, done=1.
- Handshake stalls: num_vec=3 with resp_valid gaps of 0, 2 and 5 cycles -> vec_count and signature change only on accept cycles; same final signature as the no-gap run.
- Zero-length run: num_vec=0, start=1, expected_sig=SEED -> done=1 and pass=1 next cycle; resp_ready never asserted.
- Start while busy: start pulsed during RUN -> ignored, run completes normally; start in DONE -> signature reloads to SEED and a new run begins.
